// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, reads instruction memory over req/ack,
// and hands the latched instruction to decode over valid/ready, with jump redirects.
module instr_fetch #(
    parameter int                ADDR_W   = 8,
    parameter int                INSTR_W  = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 mem_req,
    output logic [ADDR_W-1:0]    mem_addr,
    input  logic                 mem_ack,
    input  logic [INSTR_W-1:0]   mem_rdata,
    output logic                 instr_valid,
    input  logic                 instr_ready,
    output logic [3:0]           opcode,
    output logic [INSTR_W-5:0]   operand,
    output logic [ADDR_W-1:0]    instr_pc,
    input  logic                 pc_load,
    input  logic [ADDR_W-1:0]    pc_target
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   pc;
    logic [ADDR_W-1:0]   redir_pc;
    logic                redir_pend;
    logic [INSTR_W-1:0]  ir;

    function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] a);
        return a + ADDR_W'(1);
    endfunction

    // The PC only moves on an ack or outside FETCH, so it doubles as the stable read address.
    assign mem_addr = pc;
    assign opcode   = ir[INSTR_W-1 -: 4];
    assign operand  = ir[INSTR_W-5:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            redir_pc    <= RESET_PC;
            redir_pend  <= 1'b0;
            ir          <= '0;
            instr_pc    <= '0;
            mem_req     <= 1'b0;
            instr_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pc_load)
                        pc <= pc_target;
                    state   <= FETCH;
                    mem_req <= 1'b1;
                end
                FETCH: begin
                    if (mem_ack) begin
                        if (redir_pend || pc_load) begin
                            // Squashed fetch: drop the data and restart from the newest target.
                            pc         <= pc_load ? pc_target : redir_pc;
                            redir_pend <= 1'b0;
                        end else begin
                            ir          <= mem_rdata;
                            instr_pc    <= pc;
                            pc          <= pc_inc(pc);
                            state       <= HOLD;
                            mem_req     <= 1'b0;
                            instr_valid <= 1'b1;
                        end
                    end else if (pc_load) begin
                        redir_pend <= 1'b1;
                        redir_pc   <= pc_target;
                    end
                end
                HOLD: begin
                    if (pc_load || instr_ready) begin
                        if (pc_load)
                            pc <= pc_target;
                        state       <= FETCH;
                        mem_req     <= 1'b1;
                        instr_valid <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    mem_req     <= 1'b0;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios, then random traffic against a
// transaction-level model of the expected instruction address stream.
module tb_instr_fetch;
    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic               mem_req;
    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_ack;
    logic [INSTR_W-1:0] mem_rdata;
    logic               instr_valid;
    logic               instr_ready;
    logic [3:0]         opcode;
    logic [INSTR_W-5:0] operand;
    logic [ADDR_W-1:0]  instr_pc;
    logic               pc_load;
    logic [ADDR_W-1:0]  pc_target;

    instr_fetch #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .RESET_PC(8'h00)) dut (
        .clk(clk), .rst(rst),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .opcode(opcode), .operand(operand), .instr_pc(instr_pc),
        .pc_load(pc_load), .pc_target(pc_target)
    );

    always #5 clk = ~clk;

    // Memory: acks once a request has waited wait_n cycles (0 = same cycle).
    logic [INSTR_W-1:0] mem [256];
    int wait_n = 0;
    int wcnt   = 0;
    assign mem_ack   = mem_req && (wcnt >= wait_n);
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (!mem_req || mem_ack) wcnt <= 0;
        else                     wcnt <= wcnt + 1;
    end

    int checks = 0;
    int fails  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: the address of the next instruction decode should see.
    logic              mon_en    = 1'b0;
    logic [ADDR_W-1:0] exp_next  = 8'h00;
    logic              prev_wait = 1'b0;
    logic [ADDR_W-1:0] prev_addr = 8'h00;
    int                delivered = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            check("req_valid_excl", {31'd0, mem_req && instr_valid}, 32'd0);
            if (prev_wait && mem_req)
                check("addr_hold", {24'd0, mem_addr}, {24'd0, prev_addr});
            if (instr_valid) begin
                check("pc_seq", {24'd0, instr_pc}, {24'd0, exp_next});
                check("ir_data", {16'd0, opcode, operand}, {16'd0, mem[exp_next]});
            end
            prev_wait = mem_req && !mem_ack;
            prev_addr = mem_addr;
            if (instr_valid && instr_ready) begin
                exp_next = exp_next + 8'd1;
                delivered++;
            end
            if (pc_load)
                exp_next = pc_target;
        end
    end

    initial begin
        rst = 1'b1; instr_ready = 1'b0; pc_load = 1'b0; pc_target = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        mem[0] = 16'hF123;

        step(); step();
        check("rst_req",     {31'd0, mem_req}, 32'd0);
        check("rst_valid",   {31'd0, instr_valid}, 32'd0);
        check("rst_addr",    {24'd0, mem_addr}, 32'h00);
        check("rst_opcode",  {28'd0, opcode}, 32'h0);
        check("rst_operand", {20'd0, operand}, 32'h0);
        check("rst_ipc",     {24'd0, instr_pc}, 32'h00);

        rst = 1'b0;
        step();
        check("start_req",   {31'd0, mem_req}, 32'd1);
        check("start_addr",  {24'd0, mem_addr}, 32'h00);
        check("start_valid", {31'd0, instr_valid}, 32'd0);
        step();
        check("first_valid",   {31'd0, instr_valid}, 32'd1);
        check("first_opcode",  {28'd0, opcode}, 32'hF);
        check("first_operand", {20'd0, operand}, 32'h123);
        check("first_ipc",     {24'd0, instr_pc}, 32'h00);
        check("first_req",     {31'd0, mem_req}, 32'd0);

        for (int k = 0; k < 5; k++) begin
            step();
            check("stall_opcode",  {28'd0, opcode}, 32'hF);
            check("stall_operand", {20'd0, operand}, 32'h123);
            check("stall_ipc",     {24'd0, instr_pc}, 32'h00);
            check("stall_req",     {31'd0, mem_req}, 32'd0);
            check("stall_pc",      {24'd0, mem_addr}, 32'h01);
        end
        instr_ready = 1'b1;
        step();
        check("resume_req",   {31'd0, mem_req}, 32'd1);
        check("resume_addr",  {24'd0, mem_addr}, 32'h01);
        check("resume_valid", {31'd0, instr_valid}, 32'd0);
        instr_ready = 1'b0;
        step();
        check("hold1_ipc", {24'd0, instr_pc}, 32'h01);

        pc_load = 1'b1; pc_target = 8'h40;
        step();
        check("redir_valid", {31'd0, instr_valid}, 32'd0);
        check("redir_addr",  {24'd0, mem_addr}, 32'h40);
        pc_load = 1'b0;
        step();
        check("redir_ipc",  {24'd0, instr_pc}, 32'h40);
        check("redir_data", {16'd0, opcode, operand}, {16'd0, mem[8'h40]});

        pc_load = 1'b1; pc_target = 8'h40; instr_ready = 1'b1;
        step();
        check("redir_rdy_valid", {31'd0, instr_valid}, 32'd0);
        check("redir_rdy_addr",  {24'd0, mem_addr}, 32'h40);
        pc_load = 1'b0; instr_ready = 1'b0;
        step();
        check("redir_rdy_ipc", {24'd0, instr_pc}, 32'h40);

        pc_load = 1'b1; pc_target = 8'h05; wait_n = 3;
        step();
        pc_load = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("wait_req",   {31'd0, mem_req}, 32'd1);
            check("wait_addr",  {24'd0, mem_addr}, 32'h05);
            check("wait_ack",   {31'd0, mem_ack}, 32'd0);
            check("wait_valid", {31'd0, instr_valid}, 32'd0);
            step();
        end
        check("wait_ackd",   {31'd0, mem_ack}, 32'd1);
        check("wait_valid3", {31'd0, instr_valid}, 32'd0);
        step();
        check("wait_done_valid", {31'd0, instr_valid}, 32'd1);
        check("wait_done_ipc",   {24'd0, instr_pc}, 32'h05);
        check("wait_done_data",  {16'd0, opcode, operand}, {16'd0, mem[8'h05]});

        pc_load = 1'b1; pc_target = 8'h10;
        step();
        check("pend_addr0", {24'd0, mem_addr}, 32'h10);
        pc_target = 8'h80;
        step();
        check("pend_addr1", {24'd0, mem_addr}, 32'h10);
        pc_target = 8'h90;
        step();
        check("pend_addr2",  {24'd0, mem_addr}, 32'h10);
        check("pend_valid2", {31'd0, instr_valid}, 32'd0);
        pc_load = 1'b0;
        step();
        check("pend_ack",    {31'd0, mem_ack}, 32'd1);
        check("pend_addr3",  {24'd0, mem_addr}, 32'h10);
        check("pend_valid3", {31'd0, instr_valid}, 32'd0);
        wait_n = 0;
        step();
        check("pend_squash", {31'd0, instr_valid}, 32'd0);
        check("pend_req",    {31'd0, mem_req}, 32'd1);
        check("pend_target", {24'd0, mem_addr}, 32'h90);
        step();
        check("pend_ipc", {24'd0, instr_pc}, 32'h90);

        pc_load = 1'b1; pc_target = 8'hFF;
        step();
        check("wrap_addr_ff", {24'd0, mem_addr}, 32'hFF);
        pc_load = 1'b0;
        step();
        check("wrap_ipc_ff", {24'd0, instr_pc}, 32'hFF);
        instr_ready = 1'b1;
        step();
        check("wrap_addr_00", {24'd0, mem_addr}, 32'h00);
        instr_ready = 1'b0;
        step();
        check("wrap_ipc_00", {24'd0, instr_pc}, 32'h00);
        instr_ready = 1'b1; wait_n = 10;
        step();
        check("out_req",  {31'd0, mem_req}, 32'd1);
        check("out_addr", {24'd0, mem_addr}, 32'h01);
        rst = 1'b1;
        #1;
        check("async_rst_req",   {31'd0, mem_req}, 32'd0);
        check("async_rst_addr",  {24'd0, mem_addr}, 32'h00);
        check("async_rst_valid", {31'd0, instr_valid}, 32'd0);
        check("async_rst_ipc",   {24'd0, instr_pc}, 32'h00);
        step();
        rst = 1'b0; wait_n = 0; instr_ready = 1'b0;
        step();
        check("rerun_req",  {31'd0, mem_req}, 32'd1);
        check("rerun_addr", {24'd0, mem_addr}, 32'h00);

        mon_en = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            step();
            instr_ready = ($urandom_range(0, 9) < 7);
            pc_load     = ($urandom_range(0, 15) == 0);
            pc_target   = 8'($urandom);
            if (!mem_req) wait_n = $urandom_range(0, 3);
        end
        pc_load = 1'b0;
        step();
        mon_en = 1'b0;
        check("liveness", {31'd0, delivered >= 100}, 32'd1);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
